// File: rtl/field_assembler.sv
// Multi-beat field assembler: merges partial writes into a full word, then queues
// completed or flushed words with their driven mask in a small output FIFO.
module field_assembler #(
  parameter  int WIDTH     = 128,
  parameter  int NFIELDS   = 8,
  parameter  int DEPTH     = 4,
  parameter  int FILL_ONES = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NFIELDS-1:0] in_fmask,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [NFIELDS-1:0] out_drvmask,
  output logic               out_partial,
  output logic [NFIELDS-1:0] pend_mask,
  output logic [CW-1:0]      count
);
  localparam int FW = WIDTH / NFIELDS;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] FILL = (FILL_ONES != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0]   acc_data_q;
  logic [NFIELDS-1:0] acc_mask_q;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;

  logic [WIDTH-1:0]   mem_data_q [DEPTH];
  logic [NFIELDS-1:0] mem_mask_q [DEPTH];
  logic               mem_part_q [DEPTH];

  logic               full, accept, complete, push, pop;
  logic [WIDTH-1:0]   merged_data;
  logic [NFIELDS-1:0] merged_mask;

  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  assign accept   = in_valid && !full;

  // The accumulator holds FILL in every undriven field, so the merged word is
  // already correctly filled for a flush push.
  for (genvar gi = 0; gi < NFIELDS; gi++) begin : g_merge
    assign merged_data[gi*FW +: FW] = (accept && in_fmask[gi]) ? in_data[gi*FW +: FW]
                                                               : acc_data_q[gi*FW +: FW];
  end

  assign merged_mask = acc_mask_q | (accept ? in_fmask : '0);
  assign complete    = &merged_mask;
  assign push        = !full && (complete || (flush && (|merged_mask)));
  assign pop         = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data_q <= FILL;
      acc_mask_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (push) begin
        acc_data_q <= FILL;
        acc_mask_q <= '0;
        wr_ptr_q   <= ptr_inc(wr_ptr_q);
      end else begin
        acc_data_q <= merged_data;
        acc_mask_q <= merged_mask;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= merged_data;
      mem_mask_q[wr_ptr_q] <= merged_mask;
      mem_part_q[wr_ptr_q] <= !complete;
    end
  end

  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_drvmask = out_valid ? mem_mask_q[rd_ptr_q] : '0;
  assign out_partial = out_valid ? mem_part_q[rd_ptr_q] : 1'b0;
  assign pend_mask   = acc_mask_q;
  assign count       = count_q;
endmodule

// File: tb/tb_field_assembler.sv
// Scoreboard bench for field_assembler: two instances (zero fill and ones fill)
// share stimulus; a field-level reference model predicts every emitted word.
module tb_field_assembler;
  localparam int W  = 32;
  localparam int NF = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  typedef struct packed {
    logic [W-1:0]  d;
    logic [NF-1:0] m;
    logic          p;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [NF-1:0] in_fmask = '0;
  logic [W-1:0]  in_data = '0;

  logic          in_ready0, out_valid0, out_partial0, in_ready1, out_valid1, out_partial1;
  logic [W-1:0]  out_data0, out_data1;
  logic [NF-1:0] out_drvmask0, out_drvmask1, pend0, pend1;
  logic [CW-1:0] count0, count1;

  field_assembler #(.WIDTH(W), .NFIELDS(NF), .DEPTH(D), .FILL_ONES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_fmask(in_fmask), .in_data(in_data), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_drvmask(out_drvmask0), .out_partial(out_partial0),
    .pend_mask(pend0), .count(count0)
  );

  field_assembler #(.WIDTH(W), .NFIELDS(NF), .DEPTH(D), .FILL_ONES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_fmask(in_fmask), .in_data(in_data), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_drvmask(out_drvmask1), .out_partial(out_partial1),
    .pend_mask(pend1), .count(count1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: per-field values plus driven flags, and an occupancy count.
  logic [W-1:0]  mdata;
  logic [NF-1:0] mmask;
  int            mcount;
  ent_t          q0[$];
  ent_t          q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic ent_t make_word(input logic [7:0] fill, input bit part);
    ent_t e;
    for (int f = 0; f < NF; f++)
      e.d[f*8 +: 8] = mmask[f] ? mdata[f*8 +: 8] : fill;
    e.m = mmask;
    e.p = part;
    return e;
  endfunction

  task automatic model_step();
    bit full, pop, push, part;
    full = (mcount == D);
    pop  = out_ready && (mcount != 0);
    if (in_valid && !full)
      for (int f = 0; f < NF; f++)
        if (in_fmask[f]) begin
          mdata[f*8 +: 8] = in_data[f*8 +: 8];
          mmask[f] = 1'b1;
        end
    push = 1'b0;
    part = 1'b0;
    if (mmask == '1) push = 1'b1;
    else if (flush && !full && mmask != '0) begin
      push = 1'b1;
      part = 1'b1;
    end
    if (push) begin
      q0.push_back(make_word(8'h00, part));
      q1.push_back(make_word(8'hFF, part));
      mmask = '0;
    end
    if (pop) mcount--;
    if (push) mcount++;
  endtask

  task automatic beat(input bit v, input logic [NF-1:0] fm, input logic [W-1:0] d, input bit fl);
    in_valid = v;
    in_fmask = fm;
    in_data  = d;
    flush    = fl;
    @(posedge clk);
    model_step();
    #1;
    in_valid = 1'b0;
    in_fmask = '0;
    in_data  = '0;
    flush    = 1'b0;
    chk("count0", 64'(count0), 64'(mcount));
    chk("count1", 64'(count1), 64'(mcount));
    chk("pend0", 64'(pend0), 64'(mmask));
    chk("pend1", 64'(pend1), 64'(mmask));
    chk("in_ready0", 64'(in_ready0), 64'(mcount != D));
    chk("out_valid0", 64'(out_valid0), 64'(mcount != 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: consumes words whenever the DUT handshake will complete on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          total++;
          $display("FAIL sb0_unexpected: got 0x%0h, expected no word", out_data0);
        end else begin
          ent_t e;
          e = q0.pop_front();
          $display("pop0 data=%h mask=%b partial=%b", out_data0, out_drvmask0, out_partial0);
          chk("sb0_data", 64'(out_data0), 64'(e.d));
          chk("sb0_mask", 64'(out_drvmask0), 64'(e.m));
          chk("sb0_partial", 64'(out_partial0), 64'(e.p));
        end
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          total++;
          $display("FAIL sb1_unexpected: got 0x%0h, expected no word", out_data1);
        end else begin
          ent_t e;
          e = q1.pop_front();
          $display("pop1 data=%h mask=%b partial=%b", out_data1, out_drvmask1, out_partial1);
          chk("sb1_data", 64'(out_data1), 64'(e.d));
          chk("sb1_mask", 64'(out_drvmask1), 64'(e.m));
          chk("sb1_partial", 64'(out_partial1), 64'(e.p));
        end
      end
      if (!out_valid0)
        chk("gate0", 64'({out_data0, out_drvmask0, out_partial0}), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit acc_seen;
    mdata  = '0;
    mmask  = '0;
    mcount = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid0), 64'(0));
    chk("rst_count", 64'(count0), 64'(0));
    chk("rst_pend", 64'(pend0), 64'(0));
    chk("rst_ready", 64'(in_ready0), 64'(1));
    chk("rst_data", 64'({out_data0, out_drvmask0, out_partial0}), 64'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Completion over two beats
    beat(1'b1, 4'b0011, 32'h0000BBAA, 1'b0);
    beat(1'b1, 4'b1100, 32'hDDCC0000, 1'b0);
    chk("cmp_valid", 64'(out_valid0), 64'(1));
    chk("cmp_data", 64'(out_data0), 64'(32'hDDCCBBAA));
    chk("cmp_mask", 64'(out_drvmask0), 64'(4'b1111));
    chk("cmp_partial", 64'(out_partial0), 64'(0));
    chk("cmp_pend", 64'(pend0), 64'(0));
    idle(1);

    // Partial flush, both fill values
    beat(1'b1, 4'b0001, 32'h000000AA, 1'b0);
    beat(1'b1, 4'b1100, 32'hDDCC0000, 1'b0);
    beat(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("pf_data0", 64'(out_data0), 64'(32'hDDCC00AA));
    chk("pf_data1", 64'(out_data1), 64'(32'hDDCCFFAA));
    chk("pf_mask", 64'(out_drvmask0), 64'(4'b1101));
    chk("pf_partial", 64'(out_partial0), 64'(1));
    idle(1);

    // Overwrite: last write wins
    beat(1'b1, 4'b0001, 32'h00000011, 1'b0);
    beat(1'b1, 4'b0001, 32'h00000022, 1'b0);
    beat(1'b1, 4'b1110, 32'h33445500, 1'b0);
    chk("ow_data", 64'(out_data0), 64'(32'h33445522));
    chk("ow_mask", 64'(out_drvmask0), 64'(4'b1111));
    idle(1);

    // Backpressure: fill the FIFO, then hold a beat and a flush while full
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) beat(1'b1, 4'b1111, 32'(i), 1'b0);
    chk("bp_count", 64'(count0), 64'(4));
    chk("bp_ready", 64'(in_ready0), 64'(0));
    beat(1'b1, 4'b0011, 32'h5, 1'b1);
    chk("bp_hold_count", 64'(count0), 64'(4));
    chk("bp_hold_pend", 64'(pend0), 64'(0));
    out_ready = 1'b1;
    acc_seen = 1'b0;
    for (int k = 0; k < 20 && !acc_seen; k++) begin
      acc_seen = in_ready0;
      beat(1'b1, 4'b1111, 32'h5, 1'b0);
    end
    chk("bp_accept", 64'(acc_seen), 64'(1));
    idle(6);

    // Flush edge cases
    beat(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("fe_empty", 64'(out_valid0), 64'(0));
    beat(1'b1, 4'b0110, 32'h00BBCC00, 1'b1);
    chk("fe_data", 64'(out_data0), 64'(32'h00BBCC00));
    chk("fe_mask", 64'(out_drvmask0), 64'(4'b0110));
    chk("fe_partial", 64'(out_partial0), 64'(1));
    idle(2);

    // Asynchronous reset mid-assembly with words queued
    out_ready = 1'b0;
    beat(1'b1, 4'b1111, 32'hA0A0A0A0, 1'b0);
    beat(1'b1, 4'b1111, 32'hB0B0B0B0, 1'b0);
    beat(1'b1, 4'b0011, 32'h00001234, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid0), 64'(0));
    chk("ar_count", 64'(count0), 64'(0));
    chk("ar_pend", 64'(pend0), 64'(0));
    mmask  = '0;
    mcount = 0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    beat(1'b1, 4'b1100, 32'h77660000, 1'b0);
    beat(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("ar_mask", 64'(out_drvmask0), 64'(4'b1100));
    chk("ar_partial", 64'(out_partial0), 64'(1));
    chk("ar_data", 64'(out_data0), 64'(32'h77660000));
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = ((i / 40) % 3 == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      beat($urandom_range(0, 3) != 0, NF'($urandom), $urandom, $urandom_range(0, 6) == 0);
    end

    out_ready = 1'b1;
    idle(8);
    chk("drain0", 64'(q0.size()), 64'(0));
    chk("drain1", 64'(q1.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/field_assembler.md
# field_assembler

Assembles a WIDTH-bit word from NFIELDS equal-width fields that may arrive over several beats, in any order. Each emitted word carries a per-field driven mask, and undriven fields are filled with a defined constant, never X. Completed or flushed words are buffered in a DEPTH-entry output FIFO with a valid/ready handshake. The block sits between partial-write producers and consumers that need a full word with explicit driven/undriven accounting.

## Interface
- WIDTH, 128, assembled word width; must be divisible by NFIELDS.
- NFIELDS, 8, number of fields; field width FW = WIDTH/NFIELDS; field f occupies bits [f*FW +: FW].
- DEPTH, 4, output FIFO entries; DEPTH >= 1.
- FILL_ONES, 0, fill value for undriven fields: 0 gives all-zeros, 1 gives all-ones.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  write beat present.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_fmask  input  NFIELDS  fields written by this beat.
- in_data  input  WIDTH  beat data; only fields selected by in_fmask are used.
- flush  input  1  emit the current partial word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  WIDTH  assembled word.
- out_drvmask  output  NFIELDS  fields actually written.
- out_partial  output  1  word was emitted by flush, not by completion.
- pend_mask  output  NFIELDS  fields currently held in the accumulator.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- State:
  - accumulator acc_data[WIDTH] and acc_mask[NFIELDS];
  - FIFO of {data, drvmask, partial} with count.
- Ready and full:
  - full = (count == DEPTH);
  - in_ready = !full.
  - flush is honoured only when !full; while full it is ignored, with no effect.
- Accepted beat:
  - for each f with in_fmask[f]=1, field f of acc_data takes in_data field f and acc_mask[f] is set.
  - Rewriting an already-set field: last write wins, mask stays 1.
  - in_fmask = 0: beat is accepted and has no effect.
- Merged mask: m = acc_mask | (accepted ? in_fmask : 0).
- Completion: if m is all ones, the merged word is pushed with partial=0 on the same edge. The accumulator clears: mask 0, data set to fill.
- Flush (honoured, no completion, m != 0):
  - merged word is pushed with undriven fields set to fill, drvmask=m, partial=1;
  - accumulator clears.
- Flush with m == 0: no push, no state change.
- Beat and flush in the same cycle: the beat merges first, then completion or flush is evaluated on the merged word. At most one push per cycle.
- FIFO pop: out_valid && out_ready removes the head; order is strictly FIFO.
- Simultaneous push and pop: count unchanged. Push is impossible when full, because in_ready = 0.
- Output gating: out_valid = (count != 0). When out_valid = 0, out_data, out_drvmask and out_partial are driven to 0.
- pend_mask = acc_mask, registered.

## Timing
- Reset (async assert, sync-to-clk release):
  - acc_mask 0, acc_data fill, count 0;
  - out_valid 0, out_data 0, out_drvmask 0, out_partial 0;
  - pend_mask 0, in_ready 1.
- Reset mid-assembly discards the accumulator and all FIFO contents.
- Latency: a completing or flushing beat at edge N gives out_valid=1 in the cycle after edge N (one cycle).
- in_ready and out_valid derive from registered count only; there is no combinational in-to-out path.
- Back-to-back full-mask beats sustain one word per cycle when out_ready=1.

## Test plan
Unless noted: WIDTH=32, NFIELDS=4, DEPTH=4, FILL_ONES=0.
- Completion:
  - stimulus: beat fmask=0011 data=0x0000BBAA, next cycle beat fmask=1100 data=0xDDCC0000.
  - required: out_valid the cycle after the second beat; out_data=0xDDCCBBAA, drvmask=1111, partial=0; pend_mask back to 0000.
- Partial flush:
  - stimulus: beat fmask=0001 data=0xAA, beat fmask=1100 data=0xDDCC0000, then flush.
  - required: out_data=0xDDCC00AA, drvmask=1101, partial=1.
  - repeat with FILL_ONES=1: out_data=0xDDCCFFAA.
- Overwrite:
  - stimulus: fmask=0001 data 0x11, then fmask=0001 data 0x22, then fmask=1110 data 0x33445500.
  - required: single word out_data=0x33445522, drvmask=1111.
- Backpressure:
  - stimulus: out_ready=0, four beats fmask=1111 with data 1, 2, 3, 4.
  - required: count=4, in_ready=0; fifth beat (5) held and a flush issued while full has no effect.
  - then raise out_ready: words 1, 2, 3, 4 emerge in order; 5 accepted once in_ready=1.
- Flush edge cases:
  - flush with pend_mask=0000: no push.
  - beat fmask=0110 data=0x00BBCC00 with flush in the same cycle: one word 0x00BBCC00, drvmask=0110, partial=1.
- Reset mid-operation:
  - stimulus: beat fmask=0011, plus two words queued in the FIFO; pulse rst_n low asynchronously.
  - required: immediately out_valid=0, count=0, pend_mask=0000.
  - after release, beat fmask=1100 and flush give drvmask=1100, partial=1.
